dmem_copy_engine: RTL and testbench

- Bus-master engine for the single-port data memory. It copies a block of words from one address to another, or fills a block with a constant.
- It drives the memory's read-enable, write-enable, address and write-data inputs and consumes its combinational read data.
- It sits beside the datapath as the only initiator on the data-memory port while busy. The owning top level muxes it in while Busy is high.

---
 rtl/dmem_copy_engine_pkg.sv | 13 +
 rtl/dmem_copy_engine_if.sv | 33 +++
 rtl/dmem_copy_engine.sv | 108 ++++++++++
 tb/tb_dmem_copy_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_copy_engine_pkg.sv
// Shared encodings for the data-memory copy/fill engine.
// State and mode values are kept as plain constants to stay bit-compatible with legacy decode.
package dmem_copy_engine_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dmem_copy_engine_if.sv
// Request/status and data-memory bus bundle for dmem_copy_engine.
// master = the engine side; slave = the owning top level / memory side.
interface dmem_copy_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    import dmem_copy_engine_pkg::*;

    logic                  Start;
    logic                  Mode;
    logic [ADDR_WIDTH-1:0] SrcAddr;
    logic [ADDR_WIDTH-1:0] DstAddr;
    logic [ADDR_WIDTH:0]   Length;
    logic [DATA_WIDTH-1:0] FillValue;
    logic                  Busy;
    logic                  Done;
    logic                  MemReadEn;
    logic                  MemWriteEn;
    logic [ADDR_WIDTH-1:0] MemAddress;
    logic [DATA_WIDTH-1:0] MemWriteData;
    logic [DATA_WIDTH-1:0] MemReadData;

    modport master (
        input  Start, Mode, SrcAddr, DstAddr, Length, FillValue, MemReadData,
        output Busy, Done, MemReadEn, MemWriteEn, MemAddress, MemWriteData
    );

    modport slave (
        output Start, Mode, SrcAddr, DstAddr, Length, FillValue, MemReadData,
        input  Busy, Done, MemReadEn, MemWriteEn, MemAddress, MemWriteData
    );

endinterface

// File: rtl/dmem_copy_engine.sv
// Block copy / constant fill master for the single-port data memory.
// Ascending word-by-word transfer; all outputs decode from registered state only.
module dmem_copy_engine
    import dmem_copy_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_copy_engine_if.master    bus
);

    logic [1:0]            r_state;
    logic                  r_mode;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH:0]   r_len;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [ADDR_WIDTH:0]   r_idx;
    logic [DATA_WIDTH-1:0] r_data;

    logic [ADDR_WIDTH:0]   w_idx_nxt;
    logic [ADDR_WIDTH-1:0] w_src_addr;
    logic [ADDR_WIDTH-1:0] w_dst_addr;

    assign w_idx_nxt  = r_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
    // Index truncation gives the modulo-depth address wrap.
    assign w_src_addr = r_src + r_idx[ADDR_WIDTH-1:0];
    assign w_dst_addr = r_dst + r_idx[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_COPY;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_fill  <= '0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r_mode <= bus.Mode;
                        r_src  <= bus.SrcAddr;
                        r_dst  <= bus.DstAddr;
                        r_len  <= bus.Length;
                        r_fill <= bus.FillValue;
                        r_idx  <= '0;
                        if (bus.Length == '0)
                            r_state <= ST_DONE;
                        else if (bus.Mode == MODE_FILL)
                            r_state <= ST_WRITE;
                        else
                            r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_data  <= bus.MemReadData;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_idx <= w_idx_nxt;
                    if (w_idx_nxt == r_len)
                        r_state <= ST_DONE;
                    else if (r_mode == MODE_FILL)
                        r_state <= ST_WRITE;
                    else
                        r_state <= ST_READ;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.Busy         = 1'b0;
        bus.Done         = 1'b0;
        bus.MemReadEn    = 1'b0;
        bus.MemWriteEn   = 1'b0;
        bus.MemAddress   = '0;
        bus.MemWriteData = '0;
        case (r_state)
            ST_READ: begin
                bus.Busy       = 1'b1;
                bus.MemReadEn  = 1'b1;
                bus.MemAddress = w_src_addr;
            end
            ST_WRITE: begin
                bus.Busy         = 1'b1;
                bus.MemWriteEn   = 1'b1;
                bus.MemAddress   = w_dst_addr;
                bus.MemWriteData = (r_mode == MODE_FILL) ? r_fill : r_data;
            end
            ST_DONE: begin
                bus.Done = 1'b1;
            end
            default: begin
                bus.Busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed self-checking bench for dmem_copy_engine with a 32-word data memory (word k = k at init).
module tb_dmem_copy_engine;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic rst_n;
    logic init_req;

    dmem_copy_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [32];

    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 32; k++) mem[k] <= 32'(k);
        end else if (bus.MemWriteEn) begin
            mem[bus.MemAddress] <= bus.MemWriteData;
        end
    end

    assign bus.MemReadData = mem[bus.MemAddress];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Per-operation activity monitor, sampled at the falling edge.
    int cyc, done_cnt, done_cyc, busy_cnt, first_busy, last_busy, re_cnt, we_cnt, both_cnt;
    logic [AW-1:0] rd_addr [40];
    logic [AW-1:0] wr_addr [40];

    always @(negedge clk) begin
        cyc++;
        if (bus.Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.Busy) begin
            busy_cnt++;
            if (first_busy == 0) first_busy = cyc;
            last_busy = cyc;
        end
        if (bus.MemReadEn && bus.MemWriteEn) both_cnt++;
        if (bus.MemReadEn) begin
            if (re_cnt < 40) rd_addr[re_cnt] = bus.MemAddress;
            re_cnt++;
        end
        if (bus.MemWriteEn) begin
            if (we_cnt < 40) wr_addr[we_cnt] = bus.MemAddress;
            we_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0; first_busy = 0;
        last_busy = 0; re_cnt = 0; we_cnt = 0; both_cnt = 0;
    endtask

    task automatic init_mem();
        @(negedge clk);
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, {31'b0, bus.Busy}, 32'd0);
        check_val({tag, "_done"}, {31'b0, bus.Done}, 32'd0);
        check_val({tag, "_re"},   {31'b0, bus.MemReadEn}, 32'd0);
        check_val({tag, "_we"},   {31'b0, bus.MemWriteEn}, 32'd0);
        check_val({tag, "_addr"}, {27'b0, bus.MemAddress}, 32'd0);
        check_val({tag, "_wd"},   bus.MemWriteData, 32'd0);
    endtask

    // Presents a request before edge 0; monitor cycle 1 is the cycle after edge 0.
    task automatic start_op(input logic mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input logic [AW:0] len, input logic [DW-1:0] fill, input logic hold);
        @(negedge clk);
        bus.Mode = mode; bus.SrcAddr = src; bus.DstAddr = dst;
        bus.Length = len; bus.FillValue = fill; bus.Start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.Start = 1'b0;
        clear_mon();
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt != 0) break;
        end
        check_val({tag, "_seen_done"}, {31'b0, done_cnt != 0}, 32'd1);
    endtask

    initial begin
        bus.Start = 1'b0; bus.Mode = 1'b0; bus.SrcAddr = '0; bus.DstAddr = '0;
        bus.Length = '0; bus.FillValue = '0;
        rst_n = 1'b0;
        init_req = 1'b1;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        init_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Copy 2..5 -> 20..23
        init_mem();
        start_op(1'b0, 5'd2, 5'd20, 6'd4, 32'h0, 1'b0);
        wait_done("cp", 40);
        check_val("cp_done_cyc",   done_cyc, 9);
        check_val("cp_first_busy", first_busy, 1);
        check_val("cp_last_busy",  last_busy, 8);
        check_val("cp_busy_cnt",   busy_cnt, 8);
        check_val("cp_re_cnt",     re_cnt, 4);
        check_val("cp_we_cnt",     we_cnt, 4);
        check_val("cp_both",       both_cnt, 0);
        check_val("cp_rd0",        {27'b0, rd_addr[0]}, 2);
        check_val("cp_rd3",        {27'b0, rd_addr[3]}, 5);
        check_val("cp_wr0",        {27'b0, wr_addr[0]}, 20);
        check_val("cp_wr3",        {27'b0, wr_addr[3]}, 23);
        for (int k = 0; k < 4; k++) check_val($sformatf("cp_mem%0d", 20 + k), mem[20 + k], 32'(2 + k));
        check_val("cp_mem24", mem[24], 24);
        @(negedge clk);
        #1;
        check_val("cp_done_once", done_cnt, 1);
        check_idle_outputs("cp_idle");

        // Fill wrapping 30,31,0,1
        init_mem();
        start_op(1'b1, 5'd7, 5'd30, 6'd4, 32'hDEADBEEF, 1'b0);
        wait_done("fl", 40);
        check_val("fl_done_cyc", done_cyc, 5);
        check_val("fl_busy_cnt", busy_cnt, 4);
        check_val("fl_re_cnt",   re_cnt, 0);
        check_val("fl_we_cnt",   we_cnt, 4);
        check_val("fl_wr0", {27'b0, wr_addr[0]}, 30);
        check_val("fl_wr1", {27'b0, wr_addr[1]}, 31);
        check_val("fl_wr2", {27'b0, wr_addr[2]}, 0);
        check_val("fl_wr3", {27'b0, wr_addr[3]}, 1);
        check_val("fl_mem30", mem[30], 32'hDEADBEEF);
        check_val("fl_mem31", mem[31], 32'hDEADBEEF);
        check_val("fl_mem0",  mem[0],  32'hDEADBEEF);
        check_val("fl_mem1",  mem[1],  32'hDEADBEEF);
        check_val("fl_mem2",  mem[2],  2);
        check_val("fl_mem29", mem[29], 29);
        check_val("fl_mem7",  mem[7],  7);

        // Length 0
        init_mem();
        start_op(1'b0, 5'd3, 5'd9, 6'd0, 32'h0, 1'b0);
        wait_done("l0", 10);
        check_val("l0_done_cyc", done_cyc, 1);
        @(negedge clk);
        #1;
        check_val("l0_busy_cnt", busy_cnt, 0);
        check_val("l0_re_cnt",   re_cnt, 0);
        check_val("l0_we_cnt",   we_cnt, 0);
        check_val("l0_done_once", done_cnt, 1);

        // Overlapping forward copy propagates word 0
        init_mem();
        start_op(1'b0, 5'd0, 5'd1, 6'd3, 32'h0, 1'b0);
        wait_done("ov", 40);
        check_val("ov_done_cyc", done_cyc, 7);
        check_val("ov_mem0", mem[0], 0);
        check_val("ov_mem1", mem[1], 0);
        check_val("ov_mem2", mem[2], 0);
        check_val("ov_mem3", mem[3], 0);
        check_val("ov_mem4", mem[4], 4);

        // Start held high through a copy and its DONE cycle
        init_mem();
        start_op(1'b0, 5'd2, 5'd20, 6'd4, 32'h0, 1'b1);
        wait_done("hd", 40);
        check_val("hd_done_cyc", done_cyc, 9);
        check_val("hd_busy_cnt", busy_cnt, 8);
        check_val("hd_mem23", mem[23], 5);
        @(posedge clk);
        #1;
        check_val("hd_idle_busy", {31'b0, bus.Busy}, 0);
        check_val("hd_idle_done", {31'b0, bus.Done}, 0);
        bus.Mode = 1'b1; bus.DstAddr = 5'd10; bus.Length = 6'd1; bus.FillValue = 32'h000000AA;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        check_val("hd_first_done_cnt", done_cnt, 1);
        clear_mon();
        wait_done("hd2", 20);
        check_val("hd2_done_cyc", done_cyc, 2);
        check_val("hd2_mem10", mem[10], 32'h000000AA);
        check_val("hd2_mem11", mem[11], 11);

        // Reset during the second WRITE of a copy
        init_mem();
        start_op(1'b0, 5'd2, 5'd20, 6'd4, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        check_val("rs_we_before", {31'b0, bus.MemWriteEn}, 1);
        check_val("rs_addr_before", {27'b0, bus.MemAddress}, 21);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rs_in");
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("rs_hold");
        check_val("rs_no_done", done_cnt, 0);
        check_val("rs_mem20", mem[20], 2);
        check_val("rs_mem21", mem[21], 21);
        check_val("rs_mem22", mem[22], 22);
        check_val("rs_mem23", mem[23], 23);
        rst_n = 1'b1;
        start_op(1'b1, 5'd0, 5'd5, 6'd2, 32'h00000055, 1'b0);
        wait_done("rs2", 20);
        check_val("rs2_done_cyc", done_cyc, 3);
        check_val("rs2_mem5", mem[5], 32'h00000055);
        check_val("rs2_mem6", mem[6], 32'h00000055);
        check_val("rs2_mem7", mem[7], 7);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
